mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Data-memory block for the MEM stage of the pipelined processor. Word-addressed, 32-bit-wide RAM.
- Synchronous write and registered (1-cycle) read, both gated by control strobes from the EX/MEM pipeline register.
- Read data on saida feeds the MEM/WB register.
- Flags accesses outside the implemented address range.

Parameters:
- DEPTH, 256, number of 32-bit words (power of two, ≥2).
- ADDR_BITS, 8, log2(DEPTH); index bits taken from memEndereco.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- memEndereco  input  32  word address (word index, not byte address).
- memValor  input  32  write data.
- escreverMemoria  input  1  write strobe.
- lerMemoria  input  1  read strobe.
- saida  output  32  registered read data.
- erroEndereco  output  1  registered out-of-range access flag.

Interface note: one clock; reset is synchronous and active-high (ports clock, reset).

Behaviour:
- All state changes occur on the rising edge of clock only; no combinational input-to-output paths.
- Index decode:
  - idx = memEndereco[ADDR_BITS-1:0].
  - Access is in range iff memEndereco[31:ADDR_BITS] == 0.
- Reset (reset=1 at edge):
  - Every memory word cleared to 0; saida <= 0; erroEndereco <= 0.
  - Reset has priority: strobes in the same cycle are ignored, no write occurs.
- Write: escreverMemoria=1 and in range → mem[idx] <= memValor at the edge. Out of range → no write, no aliasing into low addresses.
- Read:
  - lerMemoria=1 and in range → saida <= mem[idx] at the edge (1-cycle latency).
  - lerMemoria=1 and out of range → saida <= 0.
- Idle: lerMemoria=0 → saida holds its previous value.
- Simultaneous read+write, same cycle:
  - Both are performed.
  - Write-first: saida <= memValor (new data).
  - Applies whenever in range. Since both strobes share one address, the addresses always coincide.
- erroEndereco, updated every non-reset edge:
  - <= (escreverMemoria | lerMemoria) & out_of_range.
  - Therefore 0 on idle cycles and in-range accesses.
- Memory contents persist indefinitely between accesses; only reset or a write changes them.
- X/undefined strobes are not required to be handled. All outputs are defined from the first reset onward.

Test Plan:
1. Reset for 1 cycle, then read addr 0 and addr 255 → saida=0 each, erroEndereco=0.
2. Write memEndereco=1, memValor=100, escreverMemoria=1, lerMemoria=0. Next cycle set memEndereco=1, memValor=30, escreverMemoria=0, lerMemoria=1 → after that edge saida=100 (value 30 not stored). Re-read addr 1 → still 100.
3. Write+read same cycle, addr 5, memValor=0xDEADBEEF → saida=0xDEADBEEF after that edge; subsequent read of addr 5 → 0xDEADBEEF.
4. Out of range: write memEndereco=256, memValor=7 → erroEndereco=1, no write. Read addr 0 → saida=0 (no alias), erroEndereco=0. Read addr 256 → saida=0, erroEndereco=1.
5. Hold and reset mid-operation:
   - After reading 100 from addr 1, deassert both strobes for 3 cycles → saida stays 100, erroEndereco=0.
   - Assert reset with escreverMemoria=1, addr 2, memValor=9 → saida=0. A later read of addr 2 → 0, and read of addr 1 → 0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage -- data memory for the MEM pipeline stage.
//
// Word-addressed RAM of DEPTH x 32-bit words. Writes are synchronous. Reads are
// registered with one cycle of latency. Both are enabled by strobes from the
// EX/MEM register. Any access whose upper address bits are non-zero is out of
// range. Such an access is flagged and has no other effect on memory.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-high; clears memory and outputs
//   memEndereco[31:0] word index (not a byte address)
//   memValor[31:0]   write data
//   escreverMemoria  write strobe
//   lerMemoria       read strobe
//   saida[31:0]      registered read data (feeds MEM/WB)
//   erroEndereco     registered out-of-range access flag
module mem_stage #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] memEndereco,
    input  logic [31:0] memValor,
    input  logic        escreverMemoria,
    input  logic        lerMemoria,
    output logic [31:0] saida,
    output logic        erroEndereco
);

    localparam int FLAT_BITS = ADDR_BITS + 5;  // bit index into the flattened word array

    logic [ADDR_BITS-1:0] idx;
    logic                 in_range;
    logic                 wr_en;
    logic [32*DEPTH-1:0]  words_flat;
    logic [31:0]          rd_word;

    assign idx      = memEndereco[ADDR_BITS-1:0];
    assign in_range = (memEndereco[31:ADDR_BITS] == '0);
    // The range check gates the write. This keeps out-of-range addresses
    // from aliasing onto a low word.
    assign wr_en    = escreverMemoria & in_range;

    // Each word is its own register so that reset can clear the whole array
    // in a single cycle. A flat vector collects the words for the read mux.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [31:0] word_q;

        // NOTE: a RAM normally has no reset. Here, reset must zero every
        // word, so the storage is built from flops instead of an inferred RAM.
        always_ff @(posedge clock) begin
            if (reset) begin
                word_q <= '0;
            end else if (wr_en && (idx == ADDR_BITS'(g))) begin
                word_q <= memValor;
            end
        end

        assign words_flat[32*g +: 32] = word_q;
    end

    assign rd_word = words_flat[{idx, 5'd0} +: 32];

    always_ff @(posedge clock) begin
        if (reset) begin
            saida        <= '0;
            erroEndereco <= 1'b0;
        end else begin
            if (lerMemoria) begin
                if (!in_range) begin
                    saida <= '0;
                end else if (escreverMemoria) begin
                    // Write-first. Read and write share one address, so the
                    // new data is forwarded.
                    saida <= memValor;
                end else begin
                    saida <= rd_word;
                end
            end
            erroEndereco <= (escreverMemoria | lerMemoria) & ~in_range;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage.
// Runs directed scenarios first, then randomized traffic. A plain array holds
// the expected memory contents.
module tb_mem_stage;

    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] memEndereco;
    logic [31:0] memValor;
    logic        escreverMemoria;
    logic        lerMemoria;
    logic [31:0] saida;
    logic        erroEndereco;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_saida;
    logic        exp_err;

    mem_stage #(.DEPTH(DEPTH), .ADDR_BITS(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .memEndereco     (memEndereco),
        .memValor        (memValor),
        .escreverMemoria (escreverMemoria),
        .lerMemoria      (lerMemoria),
        .saida           (saida),
        .erroEndereco    (erroEndereco)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs. Update the reference model at the edge, then
    // compare both outputs 1 time unit after the edge.
    task automatic step(input string tag, input logic rst, input logic we, input logic rd,
                        input logic [31:0] addr, input logic [31:0] val);
        logic inr;
        reset           = rst;
        escreverMemoria = we;
        lerMemoria      = rd;
        memEndereco     = addr;
        memValor        = val;
        @(posedge clock);
        inr = (addr < DEPTH);
        if (rst) begin
            foreach (model[i]) model[i] = '0;
            exp_saida = '0;
            exp_err   = 1'b0;
        end else begin
            if (rd) exp_saida = !inr ? 32'd0 : (we ? val : model[addr]);
            if (we && inr) model[addr] = val;
            exp_err = (we || rd) && !inr;
        end
        #1;
        check({tag, ".saida"}, saida, exp_saida);
        check({tag, ".err"}, {31'd0, erroEndereco}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] a;
        logic        we, rd, rst;
        exp_saida = '0;
        exp_err   = 1'b0;
        foreach (model[i]) model[i] = '0;

        // Reset, then read both ends of the array.
        step("rst",      1, 0, 0, 0, 0);
        step("rd0",      0, 0, 1, 0, 0);
        step("rd255",    0, 0, 1, 255, 0);
        check("plan1.rd255_zero", saida, 32'd0);

        // Write, then read with a different memValor that must not be stored.
        step("wr1",      0, 1, 0, 1, 100);
        step("rd1",      0, 0, 1, 1, 30);
        check("plan2.rd1_is_100", saida, 32'd100);
        step("rd1b",     0, 0, 1, 1, 0);
        check("plan2.reread_100", saida, 32'd100);

        // Simultaneous write and read of the same word.
        step("wrrd5",    0, 1, 1, 5, 32'hDEADBEEF);
        check("plan3.fwd", saida, 32'hDEADBEEF);
        step("rd5",      0, 0, 1, 5, 0);
        check("plan3.reread", saida, 32'hDEADBEEF);

        // Out-of-range accesses.
        step("wr256",    0, 1, 0, 256, 7);
        check("plan4.wr_err", {31'd0, erroEndereco}, 32'd1);
        step("rd0_alias",0, 0, 1, 0, 0);
        check("plan4.no_alias", saida, 32'd0);
        step("rd256",    0, 0, 1, 256, 0);
        check("plan4.rd_err", {31'd0, erroEndereco}, 32'd1);
        step("rdbig",    0, 0, 1, 32'h8000_0003, 0);

        // Idle hold, then reset with a write pending.
        step("rd1c",     0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step("hold", 0, 0, 0, 1, 55);
        check("plan5.hold_100", saida, 32'd100);
        step("rst_wr",   1, 1, 0, 2, 9);
        step("rd2",      0, 0, 1, 2, 0);
        check("plan5.rd2_zero", saida, 32'd0);
        step("rd1d",     0, 0, 1, 1, 0);
        check("plan5.rd1_zero", saida, 32'd0);

        // Randomized traffic. Addresses cluster on a few words so that reads
        // return data written earlier. Some addresses sit on the range
        // boundary and some are far out of range.
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'd255;
                1:       a = 32'd256;
                2:       a = $urandom;
                default: a = $urandom_range(0, 15);
            endcase
            we  = ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 1) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step("rand", rst, we, rd, a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
